// File: rtl/tff_pkg.sv
// Shared constants and parameter legality check for the T-flip-flop modulo counter.
package tff_pkg;

    localparam int   RST_VAL = 0;
    localparam logic DIR_UP  = 1'b1;
    localparam logic DIR_DN  = 1'b0;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_CLR  = 2'd1,
        OP_LOAD = 2'd2,
        OP_CNT  = 2'd3
    } tff_op_e;

    function automatic bit tff_params_ok(input int w, input int m);
        return (w >= 1) && (w <= 16) && (m >= 2) && (m <= (1 << w));
    endfunction

endpackage

// File: rtl/tff_cell.sv
// Single-bit T flip-flop: async clear to 0, toggles on each rising edge with t=1.
module tff_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    output logic q
);

    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_q <= 1'b0;
        else if (t)
            r_q <= ~r_q;
    end

    assign q = r_q;

endmodule

// File: rtl/tff_mod_counter.sv
// Modulo-N up/down counter built from a bank of T flip-flops.
// Define TFF_COUNTER_SAT_EN for saturating mode (no wrap, wrap output tied low).
module tff_mod_counter
    import tff_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    if (!tff_params_ok(WIDTH, MODULUS)) begin : g_bad_params
        $error("tff_mod_counter: illegal WIDTH/MODULUS combination");
    end

    localparam logic [WIDTH-1:0] QMAX  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] QZERO = WIDTH'(RST_VAL);

    tff_op_e          w_op;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_toggle;
    logic             w_wrap_nxt;

    always_comb begin
        if (clr)
            w_op = OP_CLR;
        else if (load)
            w_op = OP_LOAD;
        else if (en)
            w_op = OP_CNT;
        else
            w_op = OP_HOLD;
    end

    // Out-of-range q (fault only) is treated as the top value on an up count.
    always_comb begin
        w_next     = w_q;
        w_wrap_nxt = 1'b0;
        case (w_op)
            OP_CLR:  w_next = QZERO;
            OP_LOAD: w_next = (load_val > QMAX) ? QMAX : load_val;
            OP_CNT: begin
                if (up == DIR_UP) begin
                    if (w_q >= QMAX) begin
`ifdef TFF_COUNTER_SAT_EN
                        w_next = QMAX;
`else
                        w_next     = QZERO;
                        w_wrap_nxt = 1'b1;
`endif
                    end else begin
                        w_next = w_q + 1'b1;
                    end
                end else begin
                    if (w_q == QZERO) begin
`ifdef TFF_COUNTER_SAT_EN
                        w_next = QZERO;
`else
                        w_next     = QMAX;
                        w_wrap_nxt = 1'b1;
`endif
                    end else begin
                        w_next = w_q - 1'b1;
                    end
                end
            end
            default: w_next = w_q;
        endcase
    end

    assign w_toggle = w_q ^ w_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        tff_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .t     (w_toggle[i]),
            .q     (w_q[i])
        );
    end

`ifdef TFF_COUNTER_SAT_EN
    assign wrap = 1'b0;
`else
    logic r_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_wrap <= 1'b0;
        else
            r_wrap <= w_wrap_nxt;
    end

    assign wrap = r_wrap;
`endif

    assign q  = w_q;
    assign tc = en & ((up == DIR_UP) ? (w_q == QMAX) : (w_q == QZERO));

endmodule
